// File: rtl/stream_fifo.sv
// Registered valid/ready FIFO with fill count, almost-full flag and synchronous flush.
// All outputs come from flops; the head beat is pre-read into output_data each edge.
module stream_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         input_valid,
  output logic                         input_ready,
  input  logic [WIDTH-1:0]             input_data,
  output logic                         output_valid,
  input  logic                         output_ready,
  output logic [WIDTH-1:0]             output_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp, wp_n, rp_n;
  logic [CW-1:0]               cnt_n;
  logic [WIDTH-1:0]            head_n;
  logic                        insert, remove, clr;

  assign clr    = reset || flush;
  assign insert = input_valid && input_ready;
  assign remove = output_valid && output_ready;

  always_comb begin
    wp_n  = wp;
    rp_n  = rp;
    cnt_n = count;
    if (insert) wp_n = wp + AW'(1);
    if (remove) rp_n = rp + AW'(1);
    if (insert && !remove)      cnt_n = count + CW'(1);
    else if (remove && !insert) cnt_n = count - CW'(1);
  end

  // Next head: forward the incoming beat when it lands in the slot about to become head.
  always_comb begin
    head_n = mem[rp_n];
    if (insert && (wp == rp_n)) head_n = input_data;
  end

  always_ff @(posedge clk) begin
    if (insert && !clr) mem[wp] <= input_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      wp           <= wp_n;
      rp           <= rp_n;
      count        <= cnt_n;
      input_ready  <= (cnt_n != CW'(DEPTH));
      output_valid <= (cnt_n != '0);
      almost_full  <= (cnt_n >= CW'(ALMOST_FULL));
      output_data  <= head_n;
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Randomized bench for stream_fifo against a queue-based reference model.
module tb_stream_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 0;
  logic             reset = 1, flush = 0;
  logic             input_valid = 0, output_ready = 0;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_ready, output_valid, almost_full;
  logic [WIDTH-1:0] output_data;
  logic [CW-1:0]    count;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  int vectors = 0;
  int errs    = 0;
  bit chk_en  = 0;

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT comparison on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", WIDTH'(count), WIDTH'(q.size()));
      chk("output_valid", WIDTH'(output_valid), WIDTH'(q.size() != 0));
      chk("input_ready", WIDTH'(input_ready), WIDTH'(q.size() != DEPTH));
      chk("almost_full", WIDTH'(almost_full), WIDTH'(q.size() >= AF));
      if (q.size() != 0) chk("output_data", output_data, q[0]);
    end
  end

  // One cycle: drive at negedge, decide model transition from pre-edge state, apply at posedge.
  task automatic step(bit iv, logic [WIDTH-1:0] d, bit ordy, bit fl, bit rs);
    bit ins, rem;
    input_valid = iv; input_data = d; output_ready = ordy; flush = fl; reset = rs;
    ins = iv && (q.size() != DEPTH);
    rem = ordy && (q.size() != 0);
    @(posedge clk);
    if (rs || fl) q.delete();
    else begin
      if (rem) void'(q.pop_front());
      if (ins) q.push_back(d);
    end
    vectors++;
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    chk("rst_ready", WIDTH'(input_ready), 1);
    chk("rst_valid", WIDTH'(output_valid), 0);
    chk("rst_count", WIDTH'(count), 0);
    chk("rst_af", WIDTH'(almost_full), 0);

    // Fill/drain, three rounds with distinct data to cross pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(1, WIDTH'(32'hA0 + 16 * r + i), 0, 0, 0);
      chk("fill_count", WIDTH'(count), 4);
      chk("fill_ready", WIDTH'(input_ready), 0);
      chk("fill_af", WIDTH'(almost_full), 1);
      for (int i = 0; i < 4; i++) begin
        chk("drain_valid", WIDTH'(output_valid), 1);
        chk("drain_data", output_data, WIDTH'(32'hA0 + 16 * r + i));
        step(0, '0, 1, 0, 0);
      end
      chk("drain_empty", WIDTH'(output_valid), 0);
    end

    // Streaming with both sides enabled.
    for (int i = 0; i < 100; i++) begin
      step(1, WIDTH'(32'h1000 + i), 1, 0, 0);
      chk("stream_count", WIDTH'(count), 1);
      chk("stream_data", output_data, WIDTH'(32'h1000 + i));
    end
    drain();

    // Full with simultaneous pop: push refused, ready back next cycle.
    for (int i = 0; i < 4; i++) step(1, WIDTH'(32'hB0 + i), 0, 0, 0);
    step(1, 32'hDEAD, 1, 0, 0);
    chk("fullpop_count", WIDTH'(count), 3);
    chk("fullpop_ready", WIDTH'(input_ready), 1);
    chk("fullpop_head", output_data, 32'hB1);
    drain();

    // Backpressure: random pushes while downstream stalls.
    step(1, 32'hC0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(bit'($urandom_range(0, 1)), $urandom, 0, 0, 0);
      chk("bp_head", output_data, 32'hC0);
    end
    drain();

    // Flush then reset mid-operation with a concurrent push.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) step(1, WIDTH'(32'hD0 + i), 0, 0, 0);
      step(1, 32'hEEEE, 0, k == 0, k == 1);
      chk("clr_count", WIDTH'(count), 0);
      chk("clr_valid", WIDTH'(output_valid), 0);
      chk("clr_ready", WIDTH'(input_ready), 1);
      step(1, 32'hF0, 0, 0, 0);
      chk("clr_next", output_data, 32'hF0);
      drain();
    end

    // Random traffic with occasional flush.
    for (int i = 0; i < 3000; i++)
      step(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 2) != 0),
           $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
